fsm_mem_responder: RTL and testbench
====================================

Name: fsm_mem_responder

Overview:
- Memory-side responder for the multicycle control FSM's memory request interface. Serves the requests the FSM initiates in its IF, MEM_LW and MEM_SW phases.
- Accepts one word read or write per request and returns an acknowledge after a fixed, parameterised latency.
- Holds instruction/data words in an internal word array. Flags misaligned or out-of-range accesses.
- Lets the FSM stall in its fetch and memory states until ack, instead of assuming single-cycle memory.

Parameters:
- DEPTH, 1024: number of 32-bit words in the array; word index = addr[31:2].
- LATENCY, 2: cycles from request acceptance to ack; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  1  request strobe from the FSM; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; captured with req.
- addr  input  32  byte address; captured with req.
- wdata  input  32  write data; captured with req.
- rdata  output  32  read data; valid in the ack cycle, held until the next ack.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is outstanding (state BUSY).
- err  output  1  one-cycle pulse coincident with ack for a bad access.

Behaviour:
- Reset: rst_n sampled low at a rising edge forces state IDLE, ack=0, busy=0, err=0, rdata=0, internal counter 0. Array contents are not cleared.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, counter running.
- IDLE -> BUSY: on an edge with req=1.
  - Captures we, addr, wdata.
  - Loads counter = LATENCY-1.
  - Decides the error flag: bad = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
- BUSY:
  - Each edge with counter != 0 decrements the counter.
  - The edge with counter == 0 returns to IDLE and asserts ack=1 for exactly one cycle.
  - At that same edge: good write commits array[idx] <= captured wdata; good read loads rdata <= array[idx].
  - Bad access: no array write, rdata <= 0, err=1 with ack.
- Latency: req sampled at edge E0 gives ack visible after edge E0+LATENCY. With LATENCY=1, ack follows the very next edge.
- Back-to-back: req high during the ack cycle (state already IDLE) is accepted at the next edge. Sustained throughput is one request per LATENCY+1 cycles.
- req, we, addr, wdata changes while BUSY are ignored; only captured values are used. req held high across ack is treated as a new request.
- Read of a word written by the previous request returns the new data (write committed at that request's ack edge).
- rdata is unchanged by write acks and by cycles without ack.
- Reset mid-operation (rst_n low while BUSY): outstanding request abandoned; no write committed; no ack or err.
- Undriven/X on req outside reset: no requirement.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with req=1 -> ack=0, busy=0, err=0, rdata=0 throughout; no request accepted.
- Write then read, LATENCY=2: req/we=1/addr=0x10/wdata=0xDEADBEEF at E0 -> busy at E1, ack at E2, err=0. Then req/we=0/addr=0x10 at E3 -> ack at E5 with rdata=0xDEADBEEF; rdata still 0xDEADBEEF at E6.
- Misaligned and out-of-range:
  - Write to addr=0x12, wdata=0x1 -> ack+err together; a following read of 0x10 returns the prior contents.
  - Read of addr=DEPTH*4 -> ack+err with rdata=0.
- Input churn and back-to-back:
  - Change addr to 0x20 while BUSY on a read of 0x10 -> data returned is from 0x10.
  - req held high continuously -> acks at E2, E5, E8 (LATENCY=2).
- Reset mid-write: write 0x55 to 0x40, assert rst_n=0 one edge after acceptance -> no ack; subsequent read of 0x40 returns the value held before the write.
- LATENCY=1 build: req at E0 -> ack at E1; a read of a word written in the immediately preceding request returns the written value.

Source files
------------

// File: rtl/fsm_mem_responder.sv
// fsm_mem_responder: word-wide memory responder for the multicycle control FSM.
// One request is captured in IDLE, held for LATENCY cycles in BUSY, then
// completed with a one-cycle ack (plus err for misaligned/out-of-range accesses).
module fsm_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  CNT_RLD = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               bad_q, bad_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [31:0]        rdata_q;

    // Word array; never reset so contents survive rst_n.
    logic [31:0]        mem_q [DEPTH];

    logic               done;
    logic               mem_we;
    logic               rd_en;
    logic               rd_clr;

    // Next-state, capture and completion-strobe logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bad_d   = bad_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_RLD;
                    we_d    = we;
                    idx_d   = addr[IDX_W+1:2];
                    wdata_d = wdata;
                    bad_d   = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_W);
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done    = 1'b1;
                    ack_d   = 1'b1;
                    err_d   = bad_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // A reset edge must not commit an abandoned write.
        mem_we = done && rst_n && we_q && !bad_q;
        rd_en  = done && !we_q && !bad_q;
        rd_clr = done && bad_q;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Array write port: commits only at the ack edge of a good write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Registered read port; holds its value between read acks, zeroed on a bad access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (rd_en) begin
            rdata_q <= mem_q[idx_q];
        end else if (rd_clr) begin
            rdata_q <= 32'd0;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fsm_mem_responder.sv
// tb_fsm_mem_responder: table-driven vectors against a LATENCY=2 instance,
// plus hand-written sequences against a LATENCY=1 instance.
module tb_fsm_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2, DEPTH=1024 instance
    logic        rst_n, req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ack, busy, err;

    // LATENCY=1, DEPTH=16 instance
    logic        rst1_n, req1, we1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ack1, busy1, err1;

    fsm_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .err(err)
    );

    fsm_mem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
    );

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic        err;
        logic        busy;
        logic [31:0] rdata;
        logic        chk_rd;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(logic r, logic q, logic w, logic [31:0] a, logic [31:0] d,
                               logic ea, logic ee, logic eb, logic [31:0] er, logic ck);
        vec_t t;
        t.rst_n = r; t.req = q; t.we = w; t.addr = a; t.wdata = d;
        t.ack = ea; t.err = ee; t.busy = eb; t.rdata = er; t.chk_rd = ck;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Shorthand for an idle cycle with the given expectations.
    task automatic push_idle(logic ea, logic ee, logic eb, logic [31:0] er, logic ck);
        vq.push_back(v(1, 0, 0, 32'h0, 32'h0, ea, ee, eb, er, ck));
    endtask

    initial begin
        rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0;
        rst1_n = 0; req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        // reset held with req high: nothing accepted
        vq.push_back(v(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 1));
        vq.push_back(v(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 1));
        // write 0x10 = DEADBEEF: busy at E1, ack at E2
        vq.push_back(v(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 1, 32'h0, 1));
        push_idle(0, 0, 1, 32'h0, 1);
        push_idle(1, 0, 0, 32'h0, 1);
        // write 0x20 = 12345678
        vq.push_back(v(1, 1, 1, 32'h20, 32'h12345678, 0, 0, 1, 32'h0, 1));
        push_idle(0, 0, 1, 32'h0, 1);
        push_idle(1, 0, 0, 32'h0, 1);
        // read 0x10 with input churn while busy
        vq.push_back(v(1, 1, 0, 32'h10, 32'h0, 0, 0, 1, 32'h0, 1));
        vq.push_back(v(1, 1, 1, 32'h20, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 1));
        push_idle(1, 0, 0, 32'hDEADBEEF, 1);
        push_idle(0, 0, 0, 32'hDEADBEEF, 1);
        // read 0x20: churned write must not have happened
        vq.push_back(v(1, 1, 0, 32'h20, 32'h0, 0, 0, 1, 32'hDEADBEEF, 1));
        push_idle(0, 0, 1, 32'hDEADBEEF, 1);
        push_idle(1, 0, 0, 32'h12345678, 1);
        // misaligned write 0x12
        vq.push_back(v(1, 1, 1, 32'h12, 32'h1, 0, 0, 1, 32'h12345678, 1));
        push_idle(0, 0, 1, 32'h12345678, 1);
        push_idle(1, 1, 0, 32'h0, 0);
        push_idle(0, 0, 0, 32'h0, 0);
        // read 0x10 keeps prior contents
        vq.push_back(v(1, 1, 0, 32'h10, 32'h0, 0, 0, 1, 32'h0, 0));
        push_idle(0, 0, 1, 32'h0, 0);
        push_idle(1, 0, 0, 32'hDEADBEEF, 1);
        // out-of-range read at DEPTH*4
        vq.push_back(v(1, 1, 0, 32'h1000, 32'h0, 0, 0, 1, 32'hDEADBEEF, 1));
        push_idle(0, 0, 1, 32'hDEADBEEF, 1);
        push_idle(1, 1, 0, 32'h0, 1);
        // write 0x40 = AAAA5555
        vq.push_back(v(1, 1, 1, 32'h40, 32'hAAAA5555, 0, 0, 1, 32'h0, 1));
        push_idle(0, 0, 1, 32'h0, 1);
        push_idle(1, 0, 0, 32'h0, 1);
        // write 0x40 = 55, reset one edge after acceptance
        vq.push_back(v(1, 1, 1, 32'h40, 32'h55, 0, 0, 1, 32'h0, 1));
        vq.push_back(v(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 1));
        push_idle(0, 0, 0, 32'h0, 1);
        push_idle(0, 0, 0, 32'h0, 1);
        // read 0x40 returns value from before the abandoned write
        vq.push_back(v(1, 1, 0, 32'h40, 32'h0, 0, 0, 1, 32'h0, 1));
        push_idle(0, 0, 1, 32'h0, 1);
        push_idle(1, 0, 0, 32'hAAAA5555, 1);
        // req held high on read 0x10: acks every third edge
        for (int k = 0; k < 3; k++) begin
            vq.push_back(v(1, 1, 0, 32'h10, 32'h0, 0, 0, 1, (k == 0) ? 32'hAAAA5555 : 32'hDEADBEEF, 1));
            vq.push_back(v(1, 1, 0, 32'h10, 32'h0, 0, 0, 1, (k == 0) ? 32'hAAAA5555 : 32'hDEADBEEF, 1));
            vq.push_back(v(1, 1, 0, 32'h10, 32'h0, 1, 0, 0, 32'hDEADBEEF, 1));
        end
        push_idle(0, 0, 0, 32'hDEADBEEF, 1);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n = vq[i].rst_n; req = vq[i].req; we = vq[i].we;
            addr = vq[i].addr; wdata = vq[i].wdata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ack", i), {31'b0, ack}, {31'b0, vq[i].ack});
            chk($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vq[i].err});
            chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vq[i].busy});
            if (vq[i].chk_rd) chk($sformatf("v%0d rdata", i), rdata, vq[i].rdata);
            $display("vec %0d: rst_n=%0b req=%0b we=%0b addr=%08h -> ack=%0b err=%0b busy=%0b rdata=%08h",
                     i, vq[i].rst_n, vq[i].req, vq[i].we, vq[i].addr, ack, err, busy, rdata);
        end

        // LATENCY=1: write 0x8 then read it back in the very next request
        @(posedge clk); #1;
        rst1_n = 1; req1 = 1; we1 = 1; addr1 = 32'h8; wdata1 = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("l1 accept busy", {31'b0, busy1}, 32'd1);
        chk("l1 accept ack", {31'b0, ack1}, 32'd0);
        we1 = 0; wdata1 = 32'h0;
        @(posedge clk); #1;
        chk("l1 write ack", {31'b0, ack1}, 32'd1);
        chk("l1 write busy", {31'b0, busy1}, 32'd0);
        $display("l1 write 0x8: ack=%0b err=%0b", ack1, err1);
        @(posedge clk); #1;
        chk("l1 read accept busy", {31'b0, busy1}, 32'd1);
        req1 = 0;
        @(posedge clk); #1;
        chk("l1 read ack", {31'b0, ack1}, 32'd1);
        chk("l1 read err", {31'b0, err1}, 32'd0);
        chk("l1 read rdata", rdata1, 32'hCAFEF00D);
        $display("l1 read 0x8: ack=%0b rdata=%08h", ack1, rdata1);

        // LATENCY=1: out-of-range read, bounded wait for ack
        req1 = 1; addr1 = 32'h40;
        @(posedge clk); #1;
        req1 = 0;
        begin
            int n;
            n = 0;
            while (ack1 !== 1'b1 && n < 8) begin
                @(posedge clk); #1;
                n++;
            end
            chk("l1 bad ack timeout", {31'b0, ack1}, 32'd1);
            chk("l1 bad latency", n, 1);
        end
        chk("l1 bad err", {31'b0, err1}, 32'd1);
        chk("l1 bad rdata", rdata1, 32'h0);
        $display("l1 read 0x40: ack=%0b err=%0b rdata=%08h", ack1, err1, rdata1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
